// File: rtl/bitrev_pkg.sv
// Shared definitions for the bit-reversal accelerator stream adapters
// (axis2fifo and fifo2axis).
package bitrev_pkg;
  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic {
    RECV  = 1'b0,
    DRAIN = 1'b1
  } state_t;
endpackage

// File: rtl/axis2fifo_sync_fifo.sv
// Circular FIFO with separate occupancy counter and synchronous clear.
// Storage is deliberately left unreset; only pointers and count are cleared.
module sync_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_wr_en,
  input  logic [DW-1:0]    i_wr_data,
  input  logic             i_rd_en,
  output logic [DW-1:0]    o_rd_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  assign w_wr = i_wr_en && !o_full  && !i_clear;
  assign w_rd = i_rd_en && !o_empty && !i_clear;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/axis2fifo.sv
// AXI-Stream to processor-read adapter: buffers one frame, back-pressures
// the stream from tlast until the frame has been popped out.
module axis2fifo
  import bitrev_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = bitrev_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = $clog2(DEPTH) + 1,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] m_axis_tdata,
  input  logic                  m_axis_tvalid,
  output logic                  m_axis_tready,
  input  logic                  m_axis_tlast,
  input  logic                  read,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  empty,
  output logic                  full,
  output logic [CNT_W-1:0]      count,
  output logic                  frame_done,
  output logic [LEN_W-1:0]      frame_len
);
  state_t                r_state;
  logic                  r_live;
  logic [LEN_W-1:0]      r_beat_cnt;
  logic [LEN_W-1:0]      r_frame_len;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dout_valid;

  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [CNT_W-1:0]      w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_tready;
  logic                  w_accept;
  logic                  w_pop;

  sync_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (clear),
    .i_wr_en   (w_accept),
    .i_wr_data (m_axis_tdata),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // r_live keeps tready low while in reset and for the first clean edge after it.
  assign w_tready = r_live && (r_state == RECV) && !w_full;
  assign w_accept = m_axis_tvalid && w_tready;
  assign w_pop    = read && !w_empty;

  assign m_axis_tready = w_tready;
  assign dout          = r_dout;
  assign dout_valid    = r_dout_valid;
  assign empty         = w_empty;
  assign full          = w_full;
  assign count         = w_count;
  assign frame_done    = (r_state == DRAIN);
  assign frame_len     = r_frame_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RECV;
      r_live       <= 1'b0;
      r_beat_cnt   <= '0;
      r_frame_len  <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_live       <= 1'b1;
      r_dout_valid <= 1'b0;
      if (clear) begin
        r_state    <= RECV;
        r_beat_cnt <= '0;
      end else begin
        if (w_pop) begin
          r_dout       <= w_rd_data;
          r_dout_valid <= 1'b1;
        end
        case (r_state)
          RECV: begin
            if (w_accept) begin
              if (m_axis_tlast) begin
                r_frame_len <= r_beat_cnt + LEN_W'(1);
                r_beat_cnt  <= '0;
                r_state     <= DRAIN;
              end else begin
                r_beat_cnt  <= r_beat_cnt + LEN_W'(1);
              end
            end
          end
          DRAIN: begin
            if ((w_count == '0) || ((w_count == CNT_W'(1)) && w_pop))
              r_state <= RECV;
          end
          default: r_state <= RECV;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_axis2fifo.sv
// Randomized + directed bench for axis2fifo with a queue-based reference
// model and a decoupled dout scoreboard.
module tb_axis2fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int LEN_W = 16;

  logic             clk;
  logic             rst_n;
  logic [DW-1:0]    m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;
  logic             read;
  logic             clear;
  logic [DW-1:0]    dout;
  logic             dout_valid;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             frame_done;
  logic [LEN_W-1:0] frame_len;

  axis2fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .CNT_W      (CNT_W),
    .LEN_W      (LEN_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .read          (read),
    .clear         (clear),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .frame_done    (frame_done),
    .frame_len     (frame_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: buffered words, frame state, length bookkeeping.
  logic [DW-1:0]    mq[$];
  logic [DW-1:0]    sb[$];
  bit               m_started;
  bit               m_drain;
  logic [LEN_W-1:0] m_beat;
  logic [LEN_W-1:0] m_flen;
  int               errors = 0;
  int               checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_tready();
    return m_started && !m_drain && (mq.size() < DEPTH);
  endfunction

  task automatic check_outputs();
    chk("count",      32'(count),      32'(mq.size()));
    chk("empty",      32'(empty),      32'(mq.size() == 0));
    chk("full",       32'(full),       32'(mq.size() == DEPTH));
    chk("tready",     32'(m_axis_tready), 32'(m_tready()));
    chk("frame_done", 32'(frame_done), 32'(m_drain));
    chk("frame_len",  32'(frame_len),  32'(m_flen));
  endtask

  task automatic step(input bit v, input bit last, input logic [DW-1:0] data,
                      input bit rd, input bit clr, output bit acc);
    bit pop;
    bit was_drain;
    @(negedge clk);
    check_outputs();
    m_axis_tvalid = v;
    m_axis_tlast  = last;
    m_axis_tdata  = data;
    read          = rd;
    clear         = clr;
    acc       = v && m_tready();
    pop       = rd && (mq.size() > 0);
    was_drain = m_drain;
    if (clr) begin
      mq.delete();
      m_beat  = '0;
      m_drain = 1'b0;
      acc     = 1'b0;
    end else begin
      if (pop) sb.push_back(mq.pop_front());
      if (acc) begin
        mq.push_back(data);
        if (last) begin
          m_flen  = m_beat + LEN_W'(1);
          m_beat  = '0;
          m_drain = 1'b1;
        end else begin
          m_beat  = m_beat + LEN_W'(1);
        end
      end
      if (was_drain && mq.size() == 0) m_drain = 1'b0;
    end
  endtask

  task automatic idle(input bit rd);
    bit acc;
    step(1'b0, 1'b0, '0, rd, 1'b0, acc);
  endtask

  task automatic send(input logic [DW-1:0] data, input bit last, input bit rd);
    bit acc;
    int guard = 0;
    do begin
      step(1'b1, last, data, rd, 1'b0, acc);
      guard++;
    end while (!acc && guard < 50);
    if (!acc) chk("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain_all();
    int guard = 0;
    while ((mq.size() > 0 || m_drain) && guard < 20) begin
      idle(1'b1);
      guard++;
    end
    idle(1'b0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    m_axis_tvalid = 1'b0; m_axis_tlast = 1'b0; m_axis_tdata = '0;
    read = 1'b0; clear = 1'b0;
    mq.delete(); sb.delete();
    m_started = 1'b0; m_drain = 1'b0; m_beat = '0; m_flen = '0;
    #1;
    check_outputs();
    chk("rst_dout_valid", 32'(dout_valid), 32'(0));
    chk("rst_dout",       dout,            32'(0));
    repeat (n) begin
      @(negedge clk);
      check_outputs();
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_started = 1'b1;
  endtask

  // Monitor: every pop issued must surface exactly one cycle later, in order.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (dout_valid) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_dout: got %0h expected no strobe at %0t", dout, $time);
          end else begin
            chk("dout", dout, sb.pop_front());
          end
        end else if (sb.size() > 0) begin
          checks++; errors++;
          $display("FAIL missing_dout: got no strobe expected %0h at %0t", sb[0], $time);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    rst_n = 1'b0;
    m_axis_tvalid = 1'b0; m_axis_tlast = 1'b0; m_axis_tdata = '0;
    read = 1'b0; clear = 1'b0;
    do_reset(3);
    idle(1'b0);
    idle(1'b0);

    for (int i = 0; i < 4; i++) send(DW'(32'hA0 + i), (i == 3), 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("frame4_len", 32'(frame_len), 32'(4));
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b0);
    idle(1'b0);

    for (int i = 0; i < 7; i++) send(DW'(32'hB0 + i), (i == 6), 1'b1);
    drain_all();
    chk("frame7_len", 32'(frame_len), 32'(7));

    idle(1'b1);
    idle(1'b1);

    for (int c = 0; c < 400; c++) begin
      step(bit'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), $urandom,
           ($urandom_range(0, 2) != 0), 1'b0, acc);
    end
    drain_all();

    send(32'hC0, 1'b0, 1'b0);
    send(32'hC1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'hCC, 1'b1, 1'b1, acc);
    idle(1'b0);
    idle(1'b0);
    for (int i = 0; i < 3; i++) send(DW'(32'hD0 + i), (i == 2), 1'b0);
    drain_all();

    send(32'hE0, 1'b0, 1'b0);
    send(32'hE1, 1'b0, 1'b0);
    do_reset(1);
    idle(1'b0);
    for (int i = 0; i < 4; i++) send(DW'(32'hF0 + i), (i == 3), 1'b0);
    idle(1'b0);
    chk("post_reset_len", 32'(frame_len), 32'(4));
    drain_all();
    idle(1'b0);
    idle(1'b0);
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis2fifo.md
# axis2fifo

Return stage of the bit-reversal accelerator path. Accepts the HLS core's AXI-Stream output, buffers one frame in a circular FIFO, and exposes it to the processor side through a simple read/pop interface. One frame is buffered at a time: the stream is back-pressured from the frame's last beat until the processor has drained the frame.

## Interface
- DATA_WIDTH, 32: word width.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1: occupancy width.
- LEN_W, 16: frame-length counter width.

Ports (stream names follow the accelerator's master view; clock is clk, reset is rst_n):
- clk  in  1  single clock; everything rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- m_axis_tdata  in  DATA_WIDTH  result word from accelerator.
- m_axis_tvalid  in  1  beat valid.
- m_axis_tready  out  1  block can accept a beat.
- m_axis_tlast  in  1  final beat of frame.
- read  in  1  pop request from processor side.
- clear  in  1  synchronous flush.
- dout  out  DATA_WIDTH  popped word (registered).
- dout_valid  out  1  one-cycle strobe; dout holds the popped word.
- empty  out  1  occupancy == 0.
- full  out  1  occupancy == DEPTH.
- count  out  CNT_W  current occupancy.
- frame_done  out  1  high while in DRAIN.
- frame_len  out  LEN_W  beat count of the last completed frame.

## Operation
- FSM states:
  - RECV (reset state).
  - DRAIN.
- RECV: m_axis_tready = !full. A beat is accepted when tvalid && tready; the word is written at wr_ptr.
  - Accepting a beat with tlast: latch frame_len = beat_cnt+1, clear beat_cnt, go to DRAIN.
  - Accepting any other beat increments beat_cnt; it wraps at 2^LEN_W.
- DRAIN: m_axis_tready = 0.
  - Leave for RECV on the cycle count becomes 0: a pop of the final word, or entry with count already 0 (not possible unless clear).
- Pop: read && !empty. Reads at rd_ptr, advances rd_ptr, and drives dout/dout_valid next cycle. Read while empty is ignored, with no dout_valid.
  - Pops are legal in both states; the processor may drain mid-frame.
- Simultaneous accept and pop: both take effect and count is unchanged. An accept when full is impossible (tready low).
- Pointers are log2(DEPTH) bits and wrap naturally; count is tracked separately.
- clear has priority over accept and pop in the same cycle:
  - pointers, count and beat_cnt go to 0; state goes to RECV.
  - frame_len is held.
  - dout_valid is 0 the next cycle.
- Reset values:
  - m_axis_tready 0.
  - dout 0, dout_valid 0.
  - empty 1, full 0, count 0.
  - frame_done 0, frame_len 0.
  - State RECV. Storage contents are not reset.
- Reset mid-frame discards all buffered data. The upstream stream must be restarted alongside.

## Timing
- m_axis_tready is combinational from registered state and count only; there is no path from tvalid.
- Accepted beat at edge N: empty/count/full update after edge N, so the word is poppable in cycle N+1.
- Pop requested in cycle N: dout/dout_valid are valid in cycle N+1, a one-cycle latency. Back-to-back pops give one word per cycle.
- tlast accepted at edge N: frame_done is 1 and tready is 0 from cycle N+1.
- Final pop at edge M: frame_done is 0 and tready = 1 from cycle M+1, one bubble minimum between frames.
- Deassertion of rst_n is assumed synchronised externally; the first active edge must be clean.

## Structure
- Shared package bitrev_pkg holds DATA_WIDTH and the FSM state typedef, so it is shared with fifo2axis.
- Sub-module sync_fifo (storage, wr/rd pointers, count, full/empty, clear). axis2fifo wraps it with the FSM, frame counters and dout register.

## Test plan
- Reset: hold rst_n=0 → tready=0, empty=1, count=0, dout_valid=0. Release → tready=1 next cycle.
- 4-beat frame, words 0xA0..0xA3 with tlast on the 4th, no pops:
  - full=1, frame_done=1, frame_len=4, tready=0.
  - Then 4 pops → dout 0xA0..0xA3 on consecutive cycles.
  - tready=1 the cycle after the last pop.
- Streaming with concurrent pops, frame of 7 beats (> DEPTH), read held high:
  - all 7 words are returned in order.
  - count never exceeds 4; frame_len=7.
- Random tvalid/read gaps, tready drops when full: no loss or duplication across pointer wrap. Read on empty produces no dout_valid.
- clear asserted in the same cycle as an accept and a pop at count=2 → next cycle count=0, empty=1, state RECV, dout_valid=0, frame_len unchanged.
- rst_n pulled low mid-frame after 2 beats → outputs at reset values immediately. A following 4-beat frame returns correctly with frame_len=4.
